// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - Shared types, Johnson code table and code->index lookup for the step monitor
package johnson_pkg;

    localparam int JOHNSON_W = 4;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } mon_state_e;

    typedef struct packed {
        logic       legal;
        logic [2:0] index;
    } decode_t;

    // Legal Johnson sequence; element i holds the code for phase index i
    localparam logic [7:0][JOHNSON_W-1:0] LEGAL_CODES = {
        4'b1000, 4'b1100, 4'b1110, 4'b1111,
        4'b0111, 4'b0011, 4'b0001, 4'b0000
    };

    // Illegal codes decode to index 0 with legal cleared
    function automatic decode_t code_to_index(input logic [JOHNSON_W-1:0] code);
        decode_t r;
        r.legal = 1'b0;
        r.index = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (code == LEGAL_CODES[i]) begin
                r.legal = 1'b1;
                r.index = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/johnson_step_monitor_if.sv
// rtl/johnson_step_monitor_if.sv - Signal bundle between Johnson counter side and step monitor (lap_count with JOHNSON_MON_LAP_COUNT_EN)
interface johnson_step_monitor_if
    import johnson_pkg::*;
#(
    parameter int ERR_W = 8
`ifdef JOHNSON_MON_LAP_COUNT_EN
    ,
    parameter int LAP_W = 8
`endif
);

    logic [JOHNSON_W-1:0] johnson_in;
    logic                 clear_err;
    logic [2:0]           index;
    logic                 index_valid;
    logic                 wrap_pulse;
    logic                 step_err;
    logic                 err_sticky;
    logic [ERR_W-1:0]     err_count;
`ifdef JOHNSON_MON_LAP_COUNT_EN
    logic [LAP_W-1:0]     lap_count;
`endif

    modport master (
        output johnson_in, clear_err,
        input  index, index_valid, wrap_pulse, step_err, err_sticky, err_count
`ifdef JOHNSON_MON_LAP_COUNT_EN
        , input lap_count
`endif
    );

    modport slave (
        input  johnson_in, clear_err,
        output index, index_valid, wrap_pulse, step_err, err_sticky, err_count
`ifdef JOHNSON_MON_LAP_COUNT_EN
        , output lap_count
`endif
    );

endinterface

// File: rtl/johnson_decode.sv
// rtl/johnson_decode.sv - Combinational Johnson code to {legal, index} decoder
module johnson_decode
    import johnson_pkg::*;
(
    input  logic [JOHNSON_W-1:0] code_i,
    output logic                 legal_o,
    output logic [2:0]           index_o
);

    decode_t dec;

    // Table lookup of the sampled code
    always_comb begin
        dec = code_to_index(code_i);
    end

    assign legal_o = dec.legal;
    assign index_o = dec.index;

endmodule

// File: rtl/johnson_step_monitor.sv
// rtl/johnson_step_monitor.sv - Johnson counter step monitor top (optional lap counter: JOHNSON_MON_LAP_COUNT_EN)
module johnson_step_monitor
    import johnson_pkg::*;
#(
    parameter int RESYNC_LEN = 2,
    parameter int ERR_W      = 8
`ifdef JOHNSON_MON_LAP_COUNT_EN
    ,
    parameter int LAP_W      = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    johnson_step_monitor_if.slave bus
);

    mon_state_e           state_q, state_d;
    logic [2:0]           qual_q, qual_d;
    logic [JOHNSON_W-1:0] prev_q;

    logic                 cur_legal, prev_legal;
    logic [2:0]           cur_idx, prev_idx;
    logic                 is_hold, is_adv, is_err;

    logic [2:0]           index_q, index_d;
    logic                 wrap_q, wrap_d;
    logic                 step_err_q, step_err_d;
    logic                 sticky_q, sticky_d;
    logic [ERR_W-1:0]     count_q, count_d;

    johnson_decode u_dec_cur (
        .code_i  (bus.johnson_in),
        .legal_o (cur_legal),
        .index_o (cur_idx)
    );

    johnson_decode u_dec_prev (
        .code_i  (prev_q),
        .legal_o (prev_legal),
        .index_o (prev_idx)
    );

    // A previously illegal code can never be the origin of a hold or an advance
    assign is_hold = cur_legal && (bus.johnson_in == prev_q);
    assign is_adv  = cur_legal && prev_legal && (cur_idx == prev_idx + 3'd1);
    assign is_err  = !is_hold && !is_adv;

    // State, qualification counter and previous-code register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
            qual_q  <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            qual_q  <= qual_d;
            prev_q  <= bus.johnson_in;
        end
    end

    // Next state: qualify in SYNC, drop to FAULT on any bad step in TRACK
    always_comb begin
        state_d = state_q;
        qual_d  = qual_q;
        case (state_q)
            SYNC: begin
                if (is_adv) begin
                    qual_d = qual_q + 3'd1;
                end else if (is_err) begin
                    qual_d = cur_legal ? 3'd1 : 3'd0;
                end
                if (32'(qual_d) >= RESYNC_LEN) begin
                    state_d = TRACK;
                    qual_d  = '0;
                end
            end
            TRACK: begin
                if (is_err) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (bus.clear_err) begin
                    state_d = SYNC;
                    qual_d  = '0;
                end
            end
            default: begin
                state_d = SYNC;
                qual_d  = '0;
            end
        endcase
    end

    // Output next values; a TRACK error overrides a same-cycle clear
    always_comb begin
        index_d    = index_q;
        wrap_d     = 1'b0;
        step_err_d = 1'b0;
        sticky_d   = sticky_q;
        count_d    = count_q;
        if (bus.clear_err && state_q != FAULT) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end
        case (state_q)
            SYNC: begin
                if (cur_legal) begin
                    index_d = cur_idx;
                end
            end
            TRACK: begin
                if (is_adv) begin
                    index_d = cur_idx;
                    wrap_d  = (prev_idx == 3'd7);
                end else if (is_err) begin
                    step_err_d = 1'b1;
                    sticky_d   = 1'b1;
                    if (bus.clear_err) begin
                        count_d = ERR_W'(1);
                    end else if (!(&count_q)) begin
                        count_d = count_q + ERR_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            index_q    <= '0;
            wrap_q     <= 1'b0;
            step_err_q <= 1'b0;
            sticky_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            index_q    <= index_d;
            wrap_q     <= wrap_d;
            step_err_q <= step_err_d;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
        end
    end

    assign bus.index       = index_q;
    assign bus.index_valid = (state_q == TRACK);
    assign bus.wrap_pulse  = wrap_q;
    assign bus.step_err    = step_err_q;
    assign bus.err_sticky  = sticky_q;
    assign bus.err_count   = count_q;

`ifdef JOHNSON_MON_LAP_COUNT_EN
    logic [LAP_W-1:0] lap_q;

    // Lap counter steps together with each wrap pulse and wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q <= '0;
        end else if (wrap_d) begin
            lap_q <= lap_q + LAP_W'(1);
        end
    end

    assign bus.lap_count = lap_q;
`endif

endmodule

// File: tb/tb_johnson_step_monitor.sv
// tb/tb_johnson_step_monitor.sv - Self-checking bench for johnson_step_monitor (lap checks with JOHNSON_MON_LAP_COUNT_EN)
module tb_johnson_step_monitor;

    localparam int RESYNC = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    johnson_step_monitor_if #(.ERR_W(8)) bus ();

    johnson_step_monitor #(.RESYNC_LEN(RESYNC), .ERR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] code;
        logic       clr;
        logic [2:0] idx;
        logic       v, w, s, st;
        logic [7:0] cnt;
        int         lap;
    } vec_t;

    vec_t vec[31];

    // Reference model state
    int         m_mode, m_qual, m_index, m_count, m_lap;
    logic [3:0] m_prev;
    logic       m_wrap, m_step, m_sticky;

    function automatic logic [3:0] jc_code(input int k);
        return (k <= 4) ? 4'((1 << k) - 1) : 4'((15 << (k - 4)) & 15);
    endfunction

    function automatic int jc_idx(input logic [3:0] c);
        int ones = $countones(c);
        return c[3] ? 8 - ones : ones;
    endfunction

    function automatic bit jc_legal(input logic [3:0] c);
        return jc_code(jc_idx(c)) == c;
    endfunction

    function automatic vec_t mk(input logic [3:0] code, input logic clr, input int idx,
                                input logic v, input logic w, input logic s, input logic st,
                                input int cnt, input int lap);
        vec_t r;
        r.code = code; r.clr = clr; r.idx = 3'(idx); r.v = v; r.w = w; r.s = s;
        r.st = st; r.cnt = 8'(cnt); r.lap = lap;
        return r;
    endfunction

    function automatic logic [31:0] obs();
        return 32'({bus.index, bus.index_valid, bus.wrap_pulse, bus.step_err,
                    bus.err_sticky, bus.err_count});
    endfunction

    function automatic logic [31:0] model_obs();
        return 32'({3'(m_index), m_mode == 1, m_wrap, m_step, m_sticky, 8'(m_count)});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

`ifdef JOHNSON_MON_LAP_COUNT_EN
    task automatic check_lap(input string name, input int exp);
        check(name, 32'(bus.lap_count), 32'(exp % 256));
    endtask
`endif

    task automatic cyc(input logic r, input logic [3:0] c, input logic cl);
        @(negedge clk);
        rst = r;
        bus.johnson_in = c;
        bus.clear_err = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic r, input logic [3:0] c, input logic cl);
        bit legal, hold, adv;
        int ci, pi;
        if (r) begin
            m_mode = 0; m_qual = 0; m_index = 0; m_count = 0; m_lap = 0;
            m_prev = 4'b0000; m_wrap = 0; m_step = 0; m_sticky = 0;
            return;
        end
        legal = jc_legal(c);
        ci = jc_idx(c);
        pi = jc_idx(m_prev);
        hold = legal && (c == m_prev);
        adv  = legal && jc_legal(m_prev) && (ci == (pi + 1) % 8);
        m_wrap = 0;
        m_step = 0;
        if (cl && m_mode != 2) begin
            m_sticky = 0;
            m_count = 0;
        end
        if (m_mode == 0) begin
            if (legal) m_index = ci;
            if (adv) m_qual++;
            else if (!hold) m_qual = legal ? 1 : 0;
            if (m_qual >= RESYNC) begin
                m_mode = 1;
                m_qual = 0;
            end
        end else if (m_mode == 1) begin
            if (adv) begin
                m_index = ci;
                if (ci == 0) begin
                    m_wrap = 1;
                    m_lap = (m_lap + 1) % 256;
                end
            end else if (!hold) begin
                m_step = 1;
                m_sticky = 1;
                m_count = cl ? 1 : ((m_count < 255) ? m_count + 1 : 255);
                m_mode = 2;
            end
        end else if (cl) begin
            m_mode = 0;
            m_qual = 0;
        end
        m_prev = c;
    endtask

    initial begin
        int r;
        logic [3:0] gcode;
        logic mr, mc;

        rst = 1'b1;
        bus.johnson_in = 4'b0000;
        bus.clear_err = 1'b0;
        cyc(1, 4'b0000, 1'b1);
        cyc(1, 4'b0000, 1'b0);
        check("reset", obs(), 32'd0);
`ifdef JOHNSON_MON_LAP_COUNT_EN
        check_lap("reset_lap", 0);
`endif

        //           code    clr idx v  w  s  st cnt lap
        vec[0]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        vec[1]  = mk(4'b0001, 0, 1, 0, 0, 0, 0, 0, 0);
        vec[2]  = mk(4'b0011, 0, 2, 1, 0, 0, 0, 0, 0);
        vec[3]  = mk(4'b0111, 0, 3, 1, 0, 0, 0, 0, 0);
        vec[4]  = mk(4'b0111, 0, 3, 1, 0, 0, 0, 0, 0);
        vec[5]  = mk(4'b0111, 0, 3, 1, 0, 0, 0, 0, 0);
        vec[6]  = mk(4'b1111, 0, 4, 1, 0, 0, 0, 0, 0);
        vec[7]  = mk(4'b1110, 0, 5, 1, 0, 0, 0, 0, 0);
        vec[8]  = mk(4'b1100, 0, 6, 1, 0, 0, 0, 0, 0);
        vec[9]  = mk(4'b1000, 0, 7, 1, 0, 0, 0, 0, 0);
        vec[10] = mk(4'b0000, 0, 0, 1, 1, 0, 0, 0, 1);
        vec[11] = mk(4'b0000, 0, 0, 1, 0, 0, 0, 0, 1);
        vec[12] = mk(4'b0101, 0, 0, 0, 0, 1, 1, 1, 1);
        vec[13] = mk(4'b0001, 0, 0, 0, 0, 0, 1, 1, 1);
        vec[14] = mk(4'b0011, 0, 0, 0, 0, 0, 1, 1, 1);
        vec[15] = mk(4'b0011, 1, 0, 0, 0, 0, 1, 1, 1);
        vec[16] = mk(4'b0111, 0, 3, 0, 0, 0, 1, 1, 1);
        vec[17] = mk(4'b1111, 0, 4, 1, 0, 0, 1, 1, 1);
        vec[18] = mk(4'b1110, 0, 5, 1, 0, 0, 1, 1, 1);
        vec[19] = mk(4'b1100, 0, 6, 1, 0, 0, 1, 1, 1);
        vec[20] = mk(4'b1000, 0, 7, 1, 0, 0, 1, 1, 1);
        vec[21] = mk(4'b0000, 0, 0, 1, 1, 0, 1, 1, 2);
        vec[22] = mk(4'b0001, 0, 1, 1, 0, 0, 1, 1, 2);
        vec[23] = mk(4'b0111, 1, 1, 0, 0, 1, 1, 1, 2);
        vec[24] = mk(4'b0111, 0, 1, 0, 0, 0, 1, 1, 2);
        vec[25] = mk(4'b0111, 1, 1, 0, 0, 0, 1, 1, 2);
        vec[26] = mk(4'b1111, 0, 4, 0, 0, 0, 1, 1, 2);
        vec[27] = mk(4'b1110, 0, 5, 1, 0, 0, 1, 1, 2);
        vec[28] = mk(4'b1011, 0, 5, 0, 0, 1, 1, 2, 2);
        vec[29] = mk(4'b1011, 1, 5, 0, 0, 0, 1, 2, 2);
        vec[30] = mk(4'b1011, 1, 5, 0, 0, 0, 0, 0, 2);

        for (int i = 0; i < 31; i++) begin
            cyc(1'b0, vec[i].code, vec[i].clr);
            check($sformatf("vec%0d", i), obs(),
                  32'({vec[i].idx, vec[i].v, vec[i].w, vec[i].s, vec[i].st, vec[i].cnt}));
`ifdef JOHNSON_MON_LAP_COUNT_EN
            check_lap($sformatf("vec%0d_lap", i), vec[i].lap);
`endif
        end

        // Error counter saturation: one counted error per resync round
        cyc(1'b1, 4'b0000, 1'b0);
        for (int n = 1; n <= 260; n++) begin
            cyc(1'b0, 4'b0000, 1'b1);
            cyc(1'b0, 4'b0001, 1'b0);
            cyc(1'b0, 4'b0011, 1'b0);
            cyc(1'b0, 4'b0101, 1'b0);
            check($sformatf("sat%0d", n), 32'({bus.step_err, bus.err_sticky, bus.err_count}),
                  32'({1'b1, 1'b1, (n > 255) ? 8'hFF : 8'(n)}));
        end

        // Reset in the middle of a lap, overriding clear_err
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0);
        cyc(1'b0, 4'b0011, 1'b0);
        cyc(1'b0, 4'b0111, 1'b0);
        cyc(1'b0, 4'b1111, 1'b0);
        cyc(1'b0, 4'b1110, 1'b0);
        check("pre_rst_idx5", obs(), 32'({3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));
        cyc(1'b1, 4'b1100, 1'b1);
        check("mid_rst", obs(), 32'd0);
        cyc(1'b0, 4'b1100, 1'b0);
        check("resync1", obs(), 32'({3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}));
        cyc(1'b0, 4'b1000, 1'b0);
        check("resync2", obs(), 32'({3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}));

        // Randomised run against the reference model
        cyc(1'b1, 4'b0000, 1'b0);
        model_step(1'b1, 4'b0000, 1'b0);
        gcode = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                gcode = jc_legal(gcode) ? jc_code((jc_idx(gcode) + 1) % 8) : 4'b0000;
            end else if (r >= 80 && r < 90) begin
                gcode = 4'($urandom_range(0, 15));
            end else if (r >= 90) begin
                gcode = jc_code($urandom_range(0, 7));
            end
            mr = ($urandom_range(0, 149) == 0);
            mc = ($urandom_range(0, 24) == 0);
            cyc(mr, gcode, mc);
            model_step(mr, gcode, mc);
            check($sformatf("rand%0d", n), obs(), model_obs());
`ifdef JOHNSON_MON_LAP_COUNT_EN
            check_lap($sformatf("rand%0d_lap", n), m_lap);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
